// File: rtl/spi_pkg.sv
// Shared SPI types and helpers for the stream SPI slave.
`timescale 1ns/1ps
package spi_pkg;

   localparam int unsigned SPI_SYNC_MAX = 4;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_t;

   // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling edge.
   function automatic logic spi_sample_rising(input logic cpol, input logic cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/spi_cdc_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset level.
`timescale 1ns/1ps
module spi_cdc_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_stream.sv
// Oversampled SPI slave moving DATA_W-bit words; any CPOL/CPHA, either bit order.
// Define SPI_SLAVE_STREAM_ERR_EN to add the frame_err / err_cnt error reporting outputs.
`timescale 1ns/1ps
module spi_slave_stream #(
   parameter int unsigned        DATA_W      = 8,
   parameter logic               CPOL        = 1'b0,
   parameter logic               CPHA        = 1'b1,
   parameter logic               MSB_FIRST   = 1'b1,
   parameter int unsigned        SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0]  TX_IDLE     = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCK_I,
   output logic              SCK_O,
   output logic              SCK_T,
   input  logic              SS_I,
   output logic              SS_O,
   output logic              SS_T,
   input  logic              IO0_I,
   output logic              IO0_O,
   output logic              IO0_T,
   input  logic              IO1_I,
   output logic              IO1_O,
   output logic              IO1_T,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              frame_start,
   output logic              frame_end,
   output logic              tx_underrun
`ifdef SPI_SLAVE_STREAM_ERR_EN
   ,
   output logic              frame_err,
   output logic [15:0]       err_cnt
`endif
);

   import spi_pkg::*;

   localparam int unsigned     CntW       = $clog2(DATA_W);
   localparam logic [CntW-1:0] CntLast    = CntW'(DATA_W - 1);
   localparam spi_mode_t       Mode       = spi_mode_t'({CPOL, CPHA});
   localparam logic            SampleRise = spi_sample_rising(Mode[1], Mode[0]);

   if (SYNC_STAGES < 2 || SYNC_STAGES > SPI_SYNC_MAX) begin : g_bad_sync
      $error("SYNC_STAGES out of range");
   end

   logic sck_s, ss_s, mosi_s;
   logic sck_q, ss_q;
   logic rise, fall, sample_edge, shift_edge, fstart, fend, load;

   logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_shift_next, rx_data_q, rx_data_d;
   logic [CntW-1:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic              rx_done_q, rx_done_d, rx_valid_q;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d, hold_q, hold_d;
   logic              hold_full_q, hold_full_d, hold_wr;
   logic              fstart_q, fend_q, underrun_q, underrun_d;

   spi_cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
      .clk_i(clk), .rst_i(rst), .d_i(SCK_I), .q_o(sck_s)
   );
   spi_cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk_i(clk), .rst_i(rst), .d_i(SS_I), .q_o(ss_s)
   );
   spi_cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk), .rst_i(rst), .d_i(IO0_I), .q_o(mosi_s)
   );

   always_comb begin
      rise        = sck_s & ~sck_q;
      fall        = ~sck_s & sck_q;
      sample_edge = ~ss_s & (SampleRise ? rise : fall);
      shift_edge  = ~ss_s & (SampleRise ? fall : rise);
      fstart      = ss_q & ~ss_s;
      fend        = ~ss_q & ss_s;
      // CPHA=0 must present the first bit before the first SCK edge, hence the frame_start load.
      if (CPHA) begin
         load = shift_edge && (tx_cnt_q == '0);
      end else begin
         load = fstart || (shift_edge && (tx_cnt_q == CntLast));
      end
   end

   always_comb begin
      rx_shift_next = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh_q[DATA_W-1:1]};
      rx_sh_d       = rx_sh_q;
      rx_cnt_d      = rx_cnt_q;
      rx_done_d     = 1'b0;
      rx_data_d     = rx_done_q ? rx_sh_q : rx_data_q;
      if (ss_s) begin
         rx_cnt_d = '0;
      end else if (sample_edge) begin
         rx_sh_d = rx_shift_next;
         if (rx_cnt_q == CntLast) begin
            rx_cnt_d  = '0;
            rx_done_d = 1'b1;
         end else begin
            rx_cnt_d = rx_cnt_q + CntW'(1);
         end
      end
   end

   always_comb begin
      tx_sh_d    = tx_sh_q;
      tx_cnt_d   = tx_cnt_q;
      underrun_d = 1'b0;
      if (ss_s) begin
         tx_cnt_d = '0;
      end else if (shift_edge) begin
         tx_cnt_d = (tx_cnt_q == CntLast) ? '0 : tx_cnt_q + CntW'(1);
      end
      if (load) begin
         tx_sh_d    = hold_full_q ? hold_q : TX_IDLE;
         underrun_d = ~hold_full_q;
      end else if (shift_edge) begin
         tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sh_q[DATA_W-1:1]};
      end
   end

   // A write can only land in an empty register, so a same-cycle load sees it empty.
   always_comb begin
      hold_wr     = tx_valid & ~hold_full_q;
      hold_d      = hold_wr ? tx_data : hold_q;
      hold_full_d = hold_wr ? 1'b1 : (load ? 1'b0 : hold_full_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_q       <= CPOL;
         ss_q        <= 1'b1;
         rx_sh_q     <= '0;
         rx_cnt_q    <= '0;
         rx_done_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         tx_sh_q     <= TX_IDLE;
         tx_cnt_q    <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         fstart_q    <= 1'b0;
         fend_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sck_q       <= sck_s;
         ss_q        <= ss_s;
         rx_sh_q     <= rx_sh_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_done_q   <= rx_done_d;
         rx_valid_q  <= rx_done_q;
         rx_data_q   <= rx_data_d;
         tx_sh_q     <= tx_sh_d;
         tx_cnt_q    <= tx_cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         fstart_q    <= fstart;
         fend_q      <= fend;
         underrun_q  <= underrun_d;
      end
   end

`ifdef SPI_SLAVE_STREAM_ERR_EN
   logic        frame_err_q, frame_err_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [1:0]  err_inc;
   logic [16:0] err_sum;

   always_comb begin
      frame_err_d = fend & (rx_cnt_q != '0);
      err_inc     = {1'b0, frame_err_d} + {1'b0, underrun_d};
      err_sum     = {1'b0, err_cnt_q} + 17'(err_inc);
      err_cnt_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign frame_err = frame_err_q;
   assign err_cnt   = err_cnt_q;
`else
   // Without error reporting a partial word is simply discarded when SS rises.
`endif

   assign SCK_O       = 1'b0;
   assign SCK_T       = 1'b1;
   assign SS_O        = 1'b0;
   assign SS_T        = 1'b1;
   assign IO0_O       = 1'b0;
   assign IO0_T       = 1'b1;
   assign IO1_O       = MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
   assign IO1_T       = SS_I;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ready    = ~hold_full_q;
   assign frame_start = fstart_q;
   assign frame_end   = fend_q;
   assign tx_underrun = underrun_q;

   logic unused_io1;
   assign unused_io1 = IO1_I;

endmodule
